// File: rtl/serial_gpio_pkg.sv
// Shared types and helpers for the serial GPIO bridge.
// State encoding, data width and baud divisor calculation.
package serial_gpio_pkg;

   localparam int unsigned DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } txState_t;

   // Clocks per bit, rounded to nearest.
   function automatic int unsigned baud_div(input int unsigned clkFreq, input int unsigned baud);
      return (clkFreq + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/serial_gpio_reporter_uart_tx_core.sv
// Generic UART transmit core: baud counter, framing FSM and shift register.
// Accepts data when start is high and busy is low; GPIO_TX_PARITY_EN adds an even parity bit.
module uart_tx_core
   import serial_gpio_pkg::*;
#(
   parameter int unsigned DIV = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [DATA_BITS-1:0] data,
   output logic                 txd,
   output logic                 busy
);

   localparam int unsigned CntW = $clog2(DIV);
   localparam int unsigned BitW = $clog2(DATA_BITS);
   localparam logic [CntW-1:0] LastCnt = CntW'(DIV - 1);
   localparam logic [BitW-1:0] LastBit = BitW'(DATA_BITS - 1);

   txState_t             stateQ, stateD;
   logic [CntW-1:0]      baudQ, baudD;
   logic [BitW-1:0]      bitQ, bitD;
   logic [DATA_BITS-1:0] shiftQ, shiftD;
   logic                 txdQ, txdD;
   logic                 busyQ, busyD;
   logic                 baudDone;

`ifdef GPIO_TX_PARITY_EN
   logic parityQ, parityD;

   always_ff @(posedge clk) begin
      if (rst) parityQ <= 1'b0;
      else     parityQ <= parityD;
   end
`endif

   assign baudDone = (baudQ == LastCnt);

   always_comb begin
      stateD = stateQ;
      baudD  = baudQ;
      bitD   = bitQ;
      shiftD = shiftQ;
      txdD   = txdQ;
      busyD  = busyQ;
`ifdef GPIO_TX_PARITY_EN
      parityD = parityQ;
`endif
      unique case (stateQ)
         IDLE: begin
            txdD  = 1'b1;
            busyD = 1'b0;
            if (start) begin
               shiftD = data;
               txdD   = 1'b0;
               busyD  = 1'b1;
               baudD  = '0;
               stateD = START;
`ifdef GPIO_TX_PARITY_EN
               parityD = ^data;
`endif
            end
         end
         START: begin
            if (baudDone) begin
               baudD  = '0;
               bitD   = '0;
               txdD   = shiftQ[0];
               stateD = DATA;
            end else begin
               baudD = baudQ + CntW'(1);
            end
         end
         DATA: begin
            if (baudDone) begin
               baudD = '0;
               if (bitQ == LastBit) begin
`ifdef GPIO_TX_PARITY_EN
                  txdD   = parityQ;
                  stateD = PARITY;
`else
                  txdD   = 1'b1;
                  stateD = STOP;
`endif
               end else begin
                  // Shift keeps the next bit to send in position 1.
                  bitD   = bitQ + BitW'(1);
                  shiftD = shiftQ >> 1;
                  txdD   = shiftQ[1];
               end
            end else begin
               baudD = baudQ + CntW'(1);
            end
         end
`ifdef GPIO_TX_PARITY_EN
         PARITY: begin
            if (baudDone) begin
               baudD  = '0;
               txdD   = 1'b1;
               stateD = STOP;
            end else begin
               baudD = baudQ + CntW'(1);
            end
         end
`endif
         STOP: begin
            if (baudDone) begin
               baudD  = '0;
               busyD  = 1'b0;
               stateD = IDLE;
            end else begin
               baudD = baudQ + CntW'(1);
            end
         end
         default: begin
            txdD   = 1'b1;
            busyD  = 1'b0;
            baudD  = '0;
            stateD = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ <= IDLE;
         baudQ  <= '0;
         bitQ   <= '0;
         shiftQ <= '0;
         txdQ   <= 1'b1;
         busyQ  <= 1'b0;
      end else begin
         stateQ <= stateD;
         baudQ  <= baudD;
         bitQ   <= bitD;
         shiftQ <= shiftD;
         txdQ   <= txdD;
         busyQ  <= busyD;
      end
   end

   assign txd  = txdQ;
   assign busy = busyQ;

endmodule

// File: rtl/serial_gpio_reporter.sv
// Reports 8 GPIO inputs over a UART line whenever they change or on request.
// Optional even parity bit when GPIO_TX_PARITY_EN is defined (handled in uart_tx_core).
module serial_gpio_reporter
   import serial_gpio_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 25000000,
   parameter int unsigned BAUD     = 115200
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] GPin,
   input  logic                 send_req,
   output logic                 TxD,
   output logic                 busy,
   output logic [DATA_BITS-1:0] sent_val
);

   localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD);

   logic [DATA_BITS-1:0] gpS1, gpS2;
   logic [DATA_BITS-1:0] sentValQ, sentValD;
   logic                 pendingQ, pendingD;
   logic                 startReq, frameStart;

   // Only requests are remembered; value changes are re-evaluated live so that
   // a change that reverts during a frame produces nothing.
   assign startReq   = pendingQ | send_req | (gpS2 != sentValQ);
   assign frameStart = startReq & ~busy;

   always_comb begin
      pendingD = pendingQ | send_req;
      sentValD = sentValQ;
      if (frameStart) begin
         pendingD = 1'b0;
         sentValD = gpS2;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gpS1     <= '0;
         gpS2     <= '0;
         sentValQ <= '0;
         pendingQ <= 1'b0;
      end else begin
         gpS1     <= GPin;
         gpS2     <= gpS1;
         sentValQ <= sentValD;
         pendingQ <= pendingD;
      end
   end

   uart_tx_core #(
      .DIV(DIV)
   ) u_tx (
      .clk  (clk),
      .rst  (rst),
      .start(frameStart),
      .data (gpS2),
      .txd  (TxD),
      .busy (busy)
   );

   assign sent_val = sentValQ;

endmodule

// File: tb/tb_serial_gpio_reporter.sv
// Self-checking bench for serial_gpio_reporter: a line monitor decodes frames from TxD
// and each scenario compares them with the frames the reporting rules predict.
module tb_serial_gpio_reporter;

   localparam int unsigned DIV = 10;
`ifdef GPIO_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * DIV;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] GPin = 8'h00;
   logic       send_req = 1'b0;
   logic       TxD;
   logic       busy;
   logic [7:0] sent_val;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   logic [7:0] lastSent;

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       ok;
      int         startCyc;
   } frame_t;

   frame_t frames[$];

   serial_gpio_reporter #(
      .CLK_FREQ(1000000),
      .BAUD    (100000)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .GPin    (GPin),
      .send_req(send_req),
      .TxD     (TxD),
      .busy    (busy),
      .sent_val(sent_val)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Line monitor: every bit must hold for exactly DIV clocks with busy high,
   // then one idle cycle with TxD high and busy low.
   logic        mInFrame = 1'b0;
   int          mN;
   int          mStart;
   int          mB;
   logic        mOk;
   logic [10:0] mBits;

   always @(negedge clk) begin
      if (rst) begin
         mInFrame = 1'b0;
      end else begin
         if (!mInFrame && TxD === 1'b0) begin
            mInFrame = 1'b1;
            mN       = 0;
            mOk      = 1'b1;
            mStart   = cyc;
            mBits    = '0;
         end
         if (mInFrame) begin
            if (mN == FRAME) begin
               if (TxD !== 1'b1 || busy !== 1'b0) mOk = 1'b0;
               if (mBits[0] !== 1'b0 || mBits[NB-1] !== 1'b1) mOk = 1'b0;
               frames.push_back('{data: mBits[8:1], par: mBits[9], ok: mOk, startCyc: mStart});
               mInFrame = 1'b0;
            end else begin
               mB = mN / DIV;
               if (busy !== 1'b1) mOk = 1'b0;
               if (mN % DIV == 0) mBits[mB] = TxD;
               else if (TxD !== mBits[mB]) mOk = 1'b0;
               mN++;
            end
         end
      end
   end

   function automatic frame_t get_frame(input int i);
      frame_t f;
      f = '{data: 8'h00, par: 1'b0, ok: 1'b0, startCyc: -1};
      if (i < frames.size()) f = frames[i];
      return f;
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_req();
      send_req = 1'b1;
      @(negedge clk);
      send_req = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      GPin = 8'h00;
      wait_cycles(5);
      tests++; if (TxD !== 1'b1) begin fails++; $display("FAIL reset_txd: got %b want 1", TxD); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests++; if (sent_val !== 8'h00) begin fails++; $display("FAIL reset_sent: got %h want 00", sent_val); end
      rst = 1'b0;
      frames.delete();
      wait_cycles(200);
      tests++; if (frames.size() != 0) begin fails++; $display("FAIL reset_idle_frames: got %0d want 0", frames.size()); end
      tests++; if (TxD !== 1'b1) begin fails++; $display("FAIL reset_idle_txd: got %b want 1", TxD); end
      lastSent = 8'h00;
   endtask

   task automatic test_change();
      logic [7:0] v;
      int c;
      frame_t f;
      for (int k = 0; k < 5; k++) begin
         if (k == 0) v = 8'hA5;
         else do v = 8'($urandom_range(0, 255)); while (v == lastSent);
         frames.delete();
         GPin = v;
         c = cyc;
         wait_cycles(FRAME + 10);
         f = get_frame(0);
         tests++; if (frames.size() != 1) begin fails++; $display("FAIL change_count[%0d]: got %0d want 1", k, frames.size()); end
         tests++; if (f.data !== v) begin fails++; $display("FAIL change_data[%0d]: got %h want %h", k, f.data, v); end
         tests++; if (f.ok !== 1'b1) begin fails++; $display("FAIL change_framing[%0d]: got %b want 1", k, f.ok); end
         tests++; if (f.startCyc != c + 3) begin fails++; $display("FAIL change_latency[%0d]: got %0d want %0d", k, f.startCyc, c + 3); end
         tests++; if (sent_val !== v) begin fails++; $display("FAIL change_sent[%0d]: got %h want %h", k, sent_val, v); end
         lastSent = v;
      end
   endtask

   task automatic test_send_req();
      int c;
      frame_t f0, f1;
      GPin = 8'h3C;
      wait_cycles(FRAME + 10);
      lastSent = 8'h3C;
      frames.delete();
      c = cyc;
      pulse_req();
      wait_cycles(30);
      pulse_req();
      wait_cycles(5);
      pulse_req();
      wait_cycles(2 * FRAME + 20);
      f0 = get_frame(0);
      f1 = get_frame(1);
      tests++; if (frames.size() != 2) begin fails++; $display("FAIL req_count: got %0d want 2", frames.size()); end
      tests++; if (f0.data !== 8'h3C || f1.data !== 8'h3C) begin fails++; $display("FAIL req_data: got %h,%h want 3c,3c", f0.data, f1.data); end
      tests++; if (f0.ok !== 1'b1 || f1.ok !== 1'b1) begin fails++; $display("FAIL req_framing: got %b,%b want 1,1", f0.ok, f1.ok); end
      tests++; if (f0.startCyc != c + 1) begin fails++; $display("FAIL req_latency: got %0d want %0d", f0.startCyc, c + 1); end
      tests++; if (f1.startCyc != c + 1 + FRAME + 1) begin fails++; $display("FAIL req_gap: got %0d want %0d", f1.startCyc, c + FRAME + 2); end
   endtask

   task automatic test_no_queue();
      int c;
      logic [7:0] w;
      frame_t f0, f1;
      GPin = 8'h5A;
      wait_cycles(FRAME + 10);
      frames.delete();
      GPin = 8'hA5;
      c = cyc;
      wait_cycles(20);
      GPin = 8'h5A;
      wait_cycles(10);
      GPin = 8'hA5;
      wait_cycles(FRAME + 20);
      f0 = get_frame(0);
      tests++; if (frames.size() != 1) begin fails++; $display("FAIL revert_count: got %0d want 1", frames.size()); end
      tests++; if (f0.data !== 8'hA5 || f0.startCyc != c + 3) begin fails++; $display("FAIL revert_frame: got %h@%0d want a5@%0d", f0.data, f0.startCyc, c + 3); end
      // A change held across the end of a frame is sent right after it.
      for (int k = 0; k < 2; k++) begin
         if (k == 0) w = 8'h5A;
         else do w = 8'($urandom_range(0, 255)); while (w == 8'hA5);
         GPin = 8'hA5;
         wait_cycles(FRAME + 10);
         frames.delete();
         c = cyc;
         pulse_req();
         wait_cycles(30);
         GPin = w;
         wait_cycles(2 * FRAME + 20);
         f0 = get_frame(0);
         f1 = get_frame(1);
         tests++; if (frames.size() != 2) begin fails++; $display("FAIL held_count[%0d]: got %0d want 2", k, frames.size()); end
         tests++; if (f0.data !== 8'hA5 || f1.data !== w) begin fails++; $display("FAIL held_data[%0d]: got %h,%h want a5,%h", k, f0.data, f1.data, w); end
         tests++; if (f1.startCyc != c + 1 + FRAME + 1 || f1.ok !== 1'b1) begin fails++; $display("FAIL held_start[%0d]: got %0d ok %b want %0d ok 1", k, f1.startCyc, f1.ok, c + FRAME + 2); end
         lastSent = w;
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] v;
      int c;
      frame_t f;
      do v = 8'($urandom_range(1, 255)); while (v == lastSent || v == 8'h07 || v == 8'h03);
      frames.delete();
      GPin = v;
      c = cyc;
      wait_cycles(43);
      rst = 1'b1;
      @(negedge clk);
      tests++; if (TxD !== 1'b1) begin fails++; $display("FAIL midrst_txd: got %b want 1", TxD); end
      tests++; if (busy !== 1'b0 || sent_val !== 8'h00) begin fails++; $display("FAIL midrst_state: got busy %b sent %h want 0 00", busy, sent_val); end
      wait_cycles(2);
      rst = 1'b0;
      c = cyc;
      wait_cycles(FRAME + 10);
      f = get_frame(0);
      tests++; if (frames.size() != 1) begin fails++; $display("FAIL midrst_count: got %0d want 1", frames.size()); end
      tests++; if (f.data !== v || f.ok !== 1'b1 || f.startCyc != c + 3) begin fails++; $display("FAIL midrst_restart: got %h ok %b @%0d want %h ok 1 @%0d", f.data, f.ok, f.startCyc, v, c + 3); end
      lastSent = v;
   endtask

`ifdef GPIO_TX_PARITY_EN
   task automatic test_parity();
      logic [7:0] vals[2];
      frame_t f;
      vals[0] = 8'h07;
      vals[1] = 8'h03;
      for (int k = 0; k < 2; k++) begin
         frames.delete();
         GPin = vals[k];
         wait_cycles(FRAME + 10);
         f = get_frame(0);
         tests++; if (frames.size() != 1 || f.data !== vals[k] || f.ok !== 1'b1) begin fails++; $display("FAIL parity_frame[%0d]: got n=%0d %h ok %b want n=1 %h ok 1", k, frames.size(), f.data, f.ok, vals[k]); end
         tests++; if (f.par !== ^vals[k]) begin fails++; $display("FAIL parity_bit[%0d]: got %b want %b", k, f.par, ^vals[k]); end
         lastSent = vals[k];
      end
   endtask
`endif

   initial begin
      test_reset();
      test_change();
      test_send_req();
      test_no_queue();
      test_reset_mid();
`ifdef GPIO_TX_PARITY_EN
      test_parity();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
